// File: rtl/csat_sweep_driver.sv
// Exhaustive assignment sweeper for one combinational CSAT benchmark netlist.
// Issues one candidate per cycle, aligns sat_in by LATENCY, reports the first hit or exhaustion.
module csat_sweep_driver #(
  parameter int NUM_VARS = 13,
  parameter int LATENCY  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [NUM_VARS-1:0] assign_out,
  input  logic                sat_in,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                found,
  output logic [NUM_VARS-1:0] solution,
  output logic [NUM_VARS:0]   eval_count
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_REPORT} state_t;

  localparam logic [NUM_VARS-1:0] ONE_A = {{(NUM_VARS-1){1'b0}}, 1'b1};
  localparam logic [NUM_VARS:0]   ONE_E = {{NUM_VARS{1'b0}}, 1'b1};

  state_t                         r_state, w_nstate;
  // Stage 0 is the candidate currently driven; stage LATENCY is the one whose sat_in is due now.
  logic [LATENCY:0]               r_vld_pipe;
  logic [LATENCY:0][NUM_VARS-1:0] r_cand_pipe;
  logic                           r_found;
  logic [NUM_VARS-1:0]            r_solution;
  logic [NUM_VARS:0]              r_eval;

  logic [NUM_VARS-1:0] w_nassign;
  logic                w_active, w_chk, w_hit, w_last, w_younger, w_clear, w_flush;

  assign w_active = (r_state == S_SWEEP) || (r_state == S_DRAIN);
  assign w_chk    = w_active && r_vld_pipe[LATENCY];
  assign w_hit    = w_chk && sat_in;
  assign w_last   = &r_cand_pipe[0];

  always_comb begin
    w_younger = 1'b0;
    for (int i = 0; i < LATENCY; i++) w_younger = w_younger | r_vld_pipe[i];
  end

  always_comb begin
    w_nstate  = r_state;
    w_nassign = r_cand_pipe[0];
    w_clear   = 1'b0;
    w_flush   = 1'b0;
    case (r_state)
      S_IDLE: if (start) begin
        w_nstate  = S_SWEEP;
        w_nassign = '0;
        w_clear   = 1'b1;
        w_flush   = 1'b1;
      end
      S_SWEEP: begin
        if (w_hit) begin
          w_nstate = S_REPORT;
          w_flush  = 1'b1;
        end else if (w_last) begin
          w_nstate = (LATENCY == 0) ? S_REPORT : S_DRAIN;
        end else begin
          w_nassign = r_cand_pipe[0] + ONE_A;
        end
      end
      S_DRAIN: begin
        if (w_hit) begin
          w_nstate = S_REPORT;
          w_flush  = 1'b1;
        end else if (!w_younger) begin
          w_nstate = S_REPORT;
        end
      end
      S_REPORT: if (result_ready) w_nstate = S_IDLE;
      default:  w_nstate = S_IDLE;
    endcase
    if (abort) begin
      w_nstate  = S_IDLE;
      w_nassign = r_cand_pipe[0];
      w_clear   = 1'b0;
      w_flush   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_vld_pipe  <= '0;
      r_cand_pipe <= '0;
      r_found     <= 1'b0;
      r_solution  <= '0;
      r_eval      <= '0;
    end else begin
      r_state        <= w_nstate;
      r_vld_pipe[0]  <= (w_nstate == S_SWEEP);
      r_cand_pipe[0] <= w_nassign;
      for (int i = 1; i <= LATENCY; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1] & ~w_flush;
        r_cand_pipe[i] <= r_cand_pipe[i-1];
      end
      if (w_clear) begin
        r_found    <= 1'b0;
        r_solution <= '0;
        r_eval     <= '0;
      end else if (!abort) begin
        if (w_chk) r_eval <= r_eval + ONE_E;
        if (w_hit) begin
          r_found    <= 1'b1;
          r_solution <= r_cand_pipe[LATENCY];
        end
      end
    end
  end

  assign assign_out   = r_cand_pipe[0];
  assign busy         = w_active;
  assign result_valid = (r_state == S_REPORT);
  assign found        = r_found;
  assign solution     = r_solution;
  assign eval_count   = r_eval;

endmodule

// File: tb/tb_csat_sweep_driver.sv
// Bench for csat_sweep_driver: four instances (13/0, 13/3, 4/2, 4/0) with stub netlists,
// checked against a first-hit search model of the sweep.
module tb_csat_sweep_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] start = '0, abort = '0, ready = '0, sat, match;
  wire  [3:0] valid, busy, found;
  logic [12:0] a0, a1, s0, s1;
  logic [13:0] e0, e1;
  logic [3:0]  a2, a3, s2, s3;
  logic [4:0]  e2, e3;
  logic [12:0] asg [4];
  logic [12:0] sol [4];
  logic [13:0] evc [4];

  int tgt_v [4];
  bit ge_v [4];
  bit none_v [4];
  logic [7:0] sdl [4];
  int n_cmp = 0, n_bad = 0;

  csat_sweep_driver #(.NUM_VARS(13), .LATENCY(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]), .assign_out(a0),
    .sat_in(sat[0]), .busy(busy[0]), .result_valid(valid[0]), .result_ready(ready[0]),
    .found(found[0]), .solution(s0), .eval_count(e0));
  csat_sweep_driver #(.NUM_VARS(13), .LATENCY(3)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]), .assign_out(a1),
    .sat_in(sat[1]), .busy(busy[1]), .result_valid(valid[1]), .result_ready(ready[1]),
    .found(found[1]), .solution(s1), .eval_count(e1));
  csat_sweep_driver #(.NUM_VARS(4), .LATENCY(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]), .assign_out(a2),
    .sat_in(sat[2]), .busy(busy[2]), .result_valid(valid[2]), .result_ready(ready[2]),
    .found(found[2]), .solution(s2), .eval_count(e2));
  csat_sweep_driver #(.NUM_VARS(4), .LATENCY(0)) u_d3 (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .abort(abort[3]), .assign_out(a3),
    .sat_in(sat[3]), .busy(busy[3]), .result_valid(valid[3]), .result_ready(ready[3]),
    .found(found[3]), .solution(s3), .eval_count(e3));

  function automatic int lat_of(input int d);
    case (d)
      1:       return 3;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int nv_of(input int d);
    return (d < 2) ? 13 : 4;
  endfunction

  always_comb begin
    asg[0] = a0; asg[1] = a1; asg[2] = {9'd0, a2}; asg[3] = {9'd0, a3};
    sol[0] = s0; sol[1] = s1; sol[2] = {9'd0, s2}; sol[3] = {9'd0, s3};
    evc[0] = e0; evc[1] = e1; evc[2] = {9'd0, e2}; evc[3] = {9'd0, e3};
  end

  // Stub netlists: an equality or threshold predicate, delayed by the instance's latency.
  always_comb begin
    match = '0;
    sat   = '0;
    for (int d = 0; d < 4; d++) begin
      match[d] = !none_v[d] && (ge_v[d] ? (int'(asg[d]) >= tgt_v[d]) : (int'(asg[d]) == tgt_v[d]));
      sat[d]   = (lat_of(d) == 0) ? match[d] : sdl[d][lat_of(d)-1];
    end
  end

  always @(posedge clk)
    for (int d = 0; d < 4; d++) sdl[d] <= {sdl[d][6:0], match[d]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full sweep: start, wait for the report, hold it, accept it.
  task automatic sweep(input int d, input int tgt, input bit ge, input bit none,
                       input int hold, input bit restart_mid);
    int L, maxi, k, n, exp_n;
    bit exp_found, busy_bad, hold_bad;
    logic [12:0] exp_sol, exp_asg;
    logic [13:0] exp_eval;
    L = lat_of(d);
    maxi = (1 << nv_of(d)) - 1;
    k = -1;
    if (!none)
      for (int c = 0; c <= maxi; c++)
        if (ge ? (c >= tgt) : (c == tgt)) begin k = c; break; end
    exp_found = (k >= 0);
    exp_sol   = exp_found ? 13'(k) : 13'd0;
    exp_eval  = exp_found ? 14'(k + 1) : 14'(maxi + 1);
    exp_n     = exp_found ? (2 + k + L) : (2 + maxi + L);
    exp_asg   = exp_found ? 13'((k + L > maxi) ? maxi : k + L) : 13'(maxi);
    tgt_v[d] = tgt; ge_v[d] = ge; none_v[d] = none;

    start[d] = 1'b1;
    step();
    start[d] = 1'b0;
    n = 1;
    n_cmp++; if (busy[d] !== 1'b1) begin n_bad++; $display("FAIL busy_after_start d%0d: got %0b want 1", d, busy[d]); end
    busy_bad = 0;
    while (n < exp_n + 8) begin
      step();
      n++;
      start[d] = restart_mid && (n == 3);
      if (valid[d]) break;
      if (!busy[d]) busy_bad = 1;
    end
    start[d] = 1'b0;
    n_cmp++; if (n != exp_n) begin n_bad++; $display("FAIL report_latency d%0d: got %0d want %0d", d, n, exp_n); end
    if (!valid[d]) begin
      abort[d] = 1'b1; step(); abort[d] = 1'b0;
      return;
    end
    n_cmp++; if (busy_bad) begin n_bad++; $display("FAIL busy_during_sweep d%0d: got dropped want held", d); end
    n_cmp++; if (busy[d] !== 1'b0) begin n_bad++; $display("FAIL busy_in_report d%0d: got %0b want 0", d, busy[d]); end
    n_cmp++; if (found[d] !== exp_found) begin n_bad++; $display("FAIL found d%0d: got %0b want %0b", d, found[d], exp_found); end
    n_cmp++; if (sol[d] !== exp_sol) begin n_bad++; $display("FAIL solution d%0d: got %0h want %0h", d, sol[d], exp_sol); end
    n_cmp++; if (evc[d] !== exp_eval) begin n_bad++; $display("FAIL eval_count d%0d: got %0d want %0d", d, evc[d], exp_eval); end
    n_cmp++; if (asg[d] !== exp_asg) begin n_bad++; $display("FAIL assign_frozen d%0d: got %0h want %0h", d, asg[d], exp_asg); end

    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      step();
      if (!valid[d] || found[d] !== exp_found || sol[d] !== exp_sol || evc[d] !== exp_eval || asg[d] !== exp_asg)
        hold_bad = 1;
    end
    n_cmp++; if (hold_bad) begin n_bad++; $display("FAIL result_hold d%0d: got changed want stable for %0d cycles", d, hold); end

    ready[d] = 1'b1;
    step();
    ready[d] = 1'b0;
    n_cmp++; if (valid[d] !== 1'b0 || busy[d] !== 1'b0) begin n_bad++; $display("FAIL idle_after_accept d%0d: got valid=%0b busy=%0b want 0 0", d, valid[d], busy[d]); end
    n_cmp++; if (found[d] !== exp_found || sol[d] !== exp_sol) begin n_bad++; $display("FAIL result_kept d%0d: got %0b/%0h want %0b/%0h", d, found[d], sol[d], exp_found, exp_sol); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      n_cmp++; if ({valid[d], busy[d], found[d]} !== 3'b000) begin n_bad++; $display("FAIL reset_flags d%0d: got %b want 000", d, {valid[d], busy[d], found[d]}); end
      n_cmp++; if (asg[d] !== 13'd0 || sol[d] !== 13'd0 || evc[d] !== 14'd0) begin n_bad++; $display("FAIL reset_fields d%0d: got %0h/%0h/%0d want 0/0/0", d, asg[d], sol[d], evc[d]); end
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_hit_comb();
    sweep(0, 'h1FD, 1'b0, 1'b0, 5, 1'b0);
    for (int i = 0; i < 2; i++)
      sweep(0, int'($urandom_range(1500)), 1'($urandom_range(1)), 1'b0, int'($urandom_range(3)), 1'b0);
  endtask

  task automatic test_hit_pipe();
    sweep(1, 'hABC, 1'b0, 1'b0, 2, 1'b0);
    sweep(1, int'($urandom_range(1200)), 1'b1, 1'b0, 1, 1'b0);
    sweep(1, 8190, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_exhaust();
    sweep(2, 0, 1'b0, 1'b1, 1, 1'b0);
    sweep(2, 15, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_last_hit();
    sweep(3, 15, 1'b0, 1'b0, 0, 1'b0);
    sweep(3, 0, 1'b0, 1'b1, 0, 1'b0);
  endtask

  task automatic test_random_small();
    for (int i = 0; i < 10; i++)
      sweep(2 + (i % 2), int'($urandom_range(15)), 1'($urandom_range(1)),
            ($urandom_range(3) == 0), int'($urandom_range(3)), 1'b0);
  endtask

  task automatic test_abort();
    bit rose;
    tgt_v[0] = 1000; ge_v[0] = 1'b0; none_v[0] = 1'b0;
    start[0] = 1'b1; step(); start[0] = 1'b0;
    repeat (5 + int'($urandom_range(50))) step();
    abort[0] = 1'b1; step(); abort[0] = 1'b0;
    n_cmp++; if (busy[0] !== 1'b0 || valid[0] !== 1'b0) begin n_bad++; $display("FAIL abort_to_idle: got busy=%0b valid=%0b want 0 0", busy[0], valid[0]); end
    rose = 0;
    repeat (1100) begin step(); if (valid[0] || busy[0]) rose = 1; end
    n_cmp++; if (rose) begin n_bad++; $display("FAIL abort_no_report: got activity want none"); end
    start[3] = 1'b1; abort[3] = 1'b1; step(); start[3] = 1'b0; abort[3] = 1'b0;
    n_cmp++; if (busy[3] !== 1'b0) begin n_bad++; $display("FAIL start_with_abort: got busy=%0b want 0", busy[3]); end
  endtask

  task automatic test_start_ignored();
    sweep(1, 300, 1'b0, 1'b0, 0, 1'b1);
    sweep(0, 200, 1'b1, 1'b0, 0, 1'b1);
  endtask

  task automatic test_back_to_back();
    sweep(3, 7, 1'b0, 1'b0, 0, 1'b0);
    sweep(3, 2, 1'b1, 1'b0, 0, 1'b0);
    sweep(3, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    tgt_v[2] = 0; ge_v[2] = 1'b0; none_v[2] = 1'b1;
    start[2] = 1'b1; step(); start[2] = 1'b0;
    repeat (16) step();
    n_cmp++; if (busy[2] !== 1'b1 || valid[2] !== 1'b0 || asg[2] !== 13'hF) begin n_bad++; $display("FAIL drain_state: got busy=%0b valid=%0b assign=%0h want 1 0 f", busy[2], valid[2], asg[2]); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({valid[2], busy[2], found[2]} !== 3'b000 || asg[2] !== 13'd0 || evc[2] !== 14'd0 || sol[2] !== 13'd0)
      begin n_bad++; $display("FAIL async_reset: got v=%0b b=%0b f=%0b a=%0h e=%0d want all 0", valid[2], busy[2], found[2], asg[2], evc[2]); end
    rst_n = 1'b1;
    step();
    n_cmp++; if (busy[2] !== 1'b0 || valid[2] !== 1'b0) begin n_bad++; $display("FAIL after_reset_idle: got busy=%0b valid=%0b want 0 0", busy[2], valid[2]); end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) begin tgt_v[d] = 0; ge_v[d] = 1'b0; none_v[d] = 1'b1; end
    test_reset();
    test_hit_comb();
    test_hit_pipe();
    test_exhaust();
    test_last_hit();
    test_random_small();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
